// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters (CPU and
// external loader) and the single-port data SRAM.
//   cpu_*  : CPU request side (req/we/addr/wdata in, gnt/rvalid/rdata out)
//   ext_*  : external loader side, plus ext_lock for exclusive ownership
//   SRAM_* / sram_* : SRAM strobes, address, write data and read data
// Modport slave is the arbiter's view; master is the environment's view.
interface dmem_arbiter_if #(
   parameter int unsigned M = 4,
   parameter int unsigned N = 4
);
   logic         cpu_req;
   logic         cpu_we;
   logic [M-1:0] cpu_addr;
   logic [N-1:0] cpu_wdata;
   logic         cpu_gnt;
   logic         cpu_rvalid;
   logic [N-1:0] cpu_rdata;

   logic         ext_req;
   logic         ext_we;
   logic         ext_lock;
   logic [M-1:0] ext_addr;
   logic [N-1:0] ext_wdata;
   logic         ext_gnt;
   logic         ext_rvalid;
   logic [N-1:0] ext_rdata;

   logic         SRAM_readEnable;
   logic         SRAM_writeEnable;
   logic [M-1:0] sram_addr;
   logic [N-1:0] sram_wdata;
   logic [N-1:0] sram_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_gnt, cpu_rvalid, cpu_rdata,
      input  ext_req, ext_we, ext_lock, ext_addr, ext_wdata,
      output ext_gnt, ext_rvalid, ext_rdata,
      output SRAM_readEnable, SRAM_writeEnable, sram_addr, sram_wdata,
      input  sram_rdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_gnt, cpu_rvalid, cpu_rdata,
      output ext_req, ext_we, ext_lock, ext_addr, ext_wdata,
      input  ext_gnt, ext_rvalid, ext_rdata,
      input  SRAM_readEnable, SRAM_writeEnable, sram_addr, sram_wdata,
      output sram_rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data SRAM between the CPU and an external
// loader. One access at a time: IDLE arbitrates, ACC drives the SRAM for one
// cycle with a one-cycle grant pulse, RET captures read data (1-cycle SRAM
// latency) and the owner's rvalid pulses in the following cycle.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : dmem_arbiter_if.slave (CPU, external and SRAM signals)
module dmem_arbiter #(
   parameter int unsigned M = 4,
   parameter int unsigned N = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   dmem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, RET = 2'd2} state_t;
   typedef enum logic {OWN_CPU = 1'b0, OWN_EXT = 1'b1} owner_t;

   state_t       r_state,      w_state;
   owner_t       r_owner,      w_owner;
   owner_t       r_last_owner, w_last_owner;
   logic         r_we,         w_we;
   logic         r_cpu_gnt,    w_cpu_gnt;
   logic         r_ext_gnt,    w_ext_gnt;
   logic         r_rd_en,      w_rd_en;
   logic         r_wr_en,      w_wr_en;
   logic [M-1:0] r_sram_addr,  w_sram_addr;
   logic [N-1:0] r_sram_wdata, w_sram_wdata;
   logic         r_cpu_rvalid, w_cpu_rvalid;
   logic         r_ext_rvalid, w_ext_rvalid;
   logic [N-1:0] r_cpu_rdata,  w_cpu_rdata;
   logic [N-1:0] r_ext_rdata,  w_ext_rdata;

   logic         w_cpu_elig;
   logic         w_ext_elig;
   logic         w_grant;

   // The CPU is shut out entirely while the loader holds the lock.
   assign w_cpu_elig = bus.cpu_req & ~bus.ext_lock;
   assign w_ext_elig = bus.ext_req;
   assign w_grant    = (r_state == IDLE) & (w_cpu_elig | w_ext_elig);

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_owner      <= OWN_CPU;
         r_last_owner <= OWN_EXT;
         r_we         <= 1'b0;
         r_cpu_gnt    <= 1'b0;
         r_ext_gnt    <= 1'b0;
         r_rd_en      <= 1'b0;
         r_wr_en      <= 1'b0;
         r_sram_addr  <= '0;
         r_sram_wdata <= '0;
         r_cpu_rvalid <= 1'b0;
         r_ext_rvalid <= 1'b0;
         r_cpu_rdata  <= '0;
         r_ext_rdata  <= '0;
      end else begin
         r_state      <= w_state;
         r_owner      <= w_owner;
         r_last_owner <= w_last_owner;
         r_we         <= w_we;
         r_cpu_gnt    <= w_cpu_gnt;
         r_ext_gnt    <= w_ext_gnt;
         r_rd_en      <= w_rd_en;
         r_wr_en      <= w_wr_en;
         r_sram_addr  <= w_sram_addr;
         r_sram_wdata <= w_sram_wdata;
         r_cpu_rvalid <= w_cpu_rvalid;
         r_ext_rvalid <= w_ext_rvalid;
         r_cpu_rdata  <= w_cpu_rdata;
         r_ext_rdata  <= w_ext_rdata;
      end
   end

   // Next state and next output values. Pulses and SRAM drive default to 0,
   // so anything set here is visible for exactly the following cycle.
   always_comb begin
      w_state      = r_state;
      w_owner      = r_owner;
      w_last_owner = r_last_owner;
      w_we         = r_we;
      w_cpu_gnt    = 1'b0;
      w_ext_gnt    = 1'b0;
      w_rd_en      = 1'b0;
      w_wr_en      = 1'b0;
      w_sram_addr  = '0;
      w_sram_wdata = '0;
      w_cpu_rvalid = 1'b0;
      w_ext_rvalid = 1'b0;
      w_cpu_rdata  = r_cpu_rdata;
      w_ext_rdata  = r_ext_rdata;

      case (r_state)
         IDLE: begin
            // On a tie the requester that did not own the last access wins.
            if (w_cpu_elig && (!w_ext_elig || (r_last_owner == OWN_EXT))) begin
               w_owner      = OWN_CPU;
               w_we         = bus.cpu_we;
               w_sram_addr  = bus.cpu_addr;
               w_sram_wdata = bus.cpu_wdata;
               w_cpu_gnt    = 1'b1;
            end else if (w_ext_elig) begin
               w_owner      = OWN_EXT;
               w_we         = bus.ext_we;
               w_sram_addr  = bus.ext_addr;
               w_sram_wdata = bus.ext_wdata;
               w_ext_gnt    = 1'b1;
            end
            if (w_grant) begin
               w_last_owner = w_owner;
               w_wr_en      = w_we;
               w_rd_en      = ~w_we;
               w_state      = ACC;
            end
         end
         ACC: begin
            w_state = r_we ? IDLE : RET;
         end
         RET: begin
            if (r_owner == OWN_CPU) begin
               w_cpu_rdata  = bus.sram_rdata;
               w_cpu_rvalid = 1'b1;
            end else begin
               w_ext_rdata  = bus.sram_rdata;
               w_ext_rvalid = 1'b1;
            end
            w_state = IDLE;
         end
         default: begin
            w_state = IDLE;
         end
      endcase
   end

   assign bus.cpu_gnt          = r_cpu_gnt;
   assign bus.ext_gnt          = r_ext_gnt;
   assign bus.cpu_rvalid       = r_cpu_rvalid;
   assign bus.ext_rvalid       = r_ext_rvalid;
   assign bus.cpu_rdata        = r_cpu_rdata;
   assign bus.ext_rdata        = r_ext_rdata;
   assign bus.SRAM_readEnable  = r_rd_en;
   assign bus.SRAM_writeEnable = r_wr_en;
   assign bus.sram_addr        = r_sram_addr;
   assign bus.sram_wdata       = r_sram_wdata;

endmodule
